// File: rtl/buzzer_pattern_driver.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pattern_driver
// Description : Turns a one-cycle start strobe into a series of square-wave
//               beeps separated by silent gaps. The final beep can be
//               stretched to form the sprint-timer start cue. Reports busy
//               while running and a one-cycle done pulse at completion.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_pattern_driver #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int TONE_HZ   = 2000,
    parameter int BEEP_MS   = 100,
    parameter int GAP_MS    = 400,
    parameter int LONG_MULT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] beep_count,
    input  logic       long_last,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       buzzer_out
);

    // Derived timing, all in clock cycles
    localparam int HALF_CYC   = CLK_FREQ / (2 * TONE_HZ);
    localparam int BEEP_CYC   = (CLK_FREQ / 1000) * BEEP_MS;
    localparam int GAP_CYC    = (CLK_FREQ / 1000) * GAP_MS;
    localparam int c_LONG_CYC = LONG_MULT * BEEP_CYC;

    // One duration counter serves tone and gap, so size it for the longest
    localparam int c_MAX_A    = (c_LONG_CYC > BEEP_CYC) ? c_LONG_CYC : BEEP_CYC;
    localparam int c_MAX_CYC  = (c_MAX_A > GAP_CYC) ? c_MAX_A : GAP_CYC;
    localparam int c_DUR_W    = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;
    localparam int c_HALF_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

    // Counters compare against length-1
    localparam logic [c_DUR_W-1:0]  c_BEEP_LAST = c_DUR_W'(BEEP_CYC - 1);
    localparam logic [c_DUR_W-1:0]  c_LONG_LAST = c_DUR_W'(c_LONG_CYC - 1);
    localparam logic [c_DUR_W-1:0]  c_GAP_LAST  = c_DUR_W'(GAP_CYC - 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(HALF_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_DUR_W-1:0]  r_dur;
    logic [c_HALF_W-1:0] r_half;
    logic [2:0]          r_rem;
    logic                r_long;

    state_t              w_state_nxt;
    logic [c_DUR_W-1:0]  w_dur_nxt;
    logic [c_HALF_W-1:0] w_half_nxt;
    logic [2:0]          w_rem_nxt;
    logic                w_long_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_buz_nxt;
    logic [c_DUR_W-1:0]  w_tone_last;

    // Only the final beep of a long-last sequence is stretched
    assign w_tone_last = (r_long && (r_rem == 3'd1)) ? c_LONG_LAST : c_BEEP_LAST;

    // State register plus all registered outputs; reset dominates everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dur      <= '0;
            r_half     <= '0;
            r_rem      <= '0;
            r_long     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buzzer_out <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dur      <= w_dur_nxt;
            r_half     <= w_half_nxt;
            r_rem      <= w_rem_nxt;
            r_long     <= w_long_nxt;
            busy       <= w_busy_nxt;
            done       <= w_done_nxt;
            buzzer_out <= w_buz_nxt;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_half_nxt  = r_half;
        w_rem_nxt   = r_rem;
        w_long_nxt  = r_long;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;
        w_buz_nxt   = buzzer_out;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                w_buz_nxt  = 1'b0;
                // abort has no meaning here, so a simultaneous start wins
                if (start && (beep_count != 3'd0)) begin
                    w_state_nxt = S_TONE;
                    w_dur_nxt   = '0;
                    w_half_nxt  = '0;
                    w_rem_nxt   = beep_count;
                    w_long_nxt  = long_last;
                    w_busy_nxt  = 1'b1;
                    w_buz_nxt   = 1'b1;
                end
            end

            S_TONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_dur_nxt   = '0;
                    w_half_nxt  = '0;
                    w_rem_nxt   = '0;
                    w_long_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_buz_nxt   = 1'b0;
                end else if (r_dur == w_tone_last) begin
                    w_dur_nxt  = '0;
                    w_half_nxt = '0;
                    w_buz_nxt  = 1'b0;
                    w_rem_nxt  = r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        // Last beep: no trailing gap, straight to completion
                        w_state_nxt = S_IDLE;
                        w_long_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                    if (r_half == c_HALF_LAST) begin
                        w_half_nxt = '0;
                        w_buz_nxt  = ~buzzer_out;
                    end else begin
                        w_half_nxt = r_half + 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_dur_nxt   = '0;
                    w_half_nxt  = '0;
                    w_rem_nxt   = '0;
                    w_long_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_buz_nxt   = 1'b0;
                end else if (r_dur == c_GAP_LAST) begin
                    // Fresh half-period count so every beep opens high
                    w_state_nxt = S_TONE;
                    w_dur_nxt   = '0;
                    w_half_nxt  = '0;
                    w_buz_nxt   = 1'b1;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_dur_nxt   = '0;
                w_half_nxt  = '0;
                w_rem_nxt   = '0;
                w_long_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
                w_buz_nxt   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
